// File: rtl/bb_psum_accum.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// bb_psum_accum
//
// Partial-sum accumulator and requantizer placed directly after the BitBlade
// core. On every core done pulse it adds the PE_ARRAY partial sums into
// per-lane accumulators. After the programmed number of tiles it requantizes
// each lane and streams the results out one word per handshake. Each word
// goes through a rounding right shift, an optional ReLU and saturation.
//
// Ports
//   CLK           clock
//   RST           asynchronous active-low reset
//   i_Start       one-cycle pulse: latch config, clear accumulators, accumulate
//   i_Num_Tiles   done pulses per output set (0 behaves as 1)
//   i_Shift       arithmetic right-shift amount used for requantization
//   i_Relu        clamp negative results to zero before saturation
//   i_Done        core done pulse, i_Psum valid in the same cycle
//   i_Psum        packed signed partial sums, lane k at [BITS_PSUM*k +: BITS_PSUM]
//   o_Out_Valid   output word valid
//   i_Out_Ready   downstream accepts the current word
//   o_Out_Data    requantized signed value of lane o_Out_Idx
//   o_Out_Idx     lane index of the current word
//   o_Last        marks the word of lane PE_ARRAY-1
//   o_Busy        accumulating or draining
//   o_Overrun     sticky: a done pulse arrived while not accumulating
// ---------------------------------------------------------------------------
module bb_psum_accum #(
   parameter int PE_ARRAY  = 16,
   parameter int BITS_PSUM = 20,
   parameter int BITS_OUT  = 8,
   parameter int ACC_EXT   = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          i_Start,
   input  logic [7:0]                    i_Num_Tiles,
   input  logic [4:0]                    i_Shift,
   input  logic                          i_Relu,
   input  logic                          i_Done,
   input  logic [BITS_PSUM*PE_ARRAY-1:0] i_Psum,
   output logic                          o_Out_Valid,
   input  logic                          i_Out_Ready,
   output logic [BITS_OUT-1:0]           o_Out_Data,
   output logic [3:0]                    o_Out_Idx,
   output logic                          o_Last,
   output logic                          o_Busy,
   output logic                          o_Overrun
);

   localparam int ACC_W = BITS_PSUM + ACC_EXT;
   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PE_ARRAY - 1);

   // Saturation bounds held at the width of the shifted intermediate
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (BITS_OUT - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [ACC_W-1:0]    acc_q [PE_ARRAY];
   logic signed [ACC_W-1:0]    acc_d [PE_ARRAY];
   logic signed [ACC_W-1:0]    psum_ext [PE_ARRAY];
   logic [7:0]                 cnt_q, cnt_d;
   logic [7:0]                 num_q, num_d;
   logic [4:0]                 shift_q, shift_d;
   logic                       relu_q, relu_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic signed [BITS_OUT-1:0] data_q, data_d;
   logic                       overrun_q, overrun_d;

   logic                       start_acc;
   logic                       done_acc;
   logic                       last_tile;
   logic                       hs;
   logic                       hs_last;
   logic                       overrun_set;
   logic [7:0]                 cnt_inc;
   logic [IDX_W-1:0]           idx_nxt;

   // Rounding shift (round half up), optional ReLU, then saturation.
   // The shift result is one bit wider than the accumulator so adding the
   // rounding constant can never overflow.
   function automatic logic signed [BITS_OUT-1:0] requant(
      input logic signed [ACC_W-1:0] a,
      input logic [4:0]              s,
      input logic                    relu
   );
      logic signed [ACC_W:0] wide;
      logic signed [ACC_W:0] rnd;
      logic signed [ACC_W:0] r;
      wide = {a[ACC_W-1], a};
      rnd  = '0;
      if (s == 5'd0) begin
         r = wide;
      end else if (int'(s) >= ACC_W) begin
         // Everything shifted out: only the sign survives
         r = a[ACC_W-1] ? '1 : '0;
      end else begin
         rnd = (ACC_W+1)'(1) << (s - 5'd1);
         r   = (wide + rnd) >>> s;
      end
      if (relu && r < 0) begin
         r = '0;
      end
      if (r > SAT_MAX) begin
         r = SAT_MAX;
      end else if (r < SAT_MIN) begin
         r = SAT_MIN;
      end
      return r[BITS_OUT-1:0];
   endfunction

   // Lane extraction with sign extension to accumulator width
   always_comb begin
      for (int k = 0; k < PE_ARRAY; k++) begin
         psum_ext[k] = {{ACC_EXT{i_Psum[BITS_PSUM*k + BITS_PSUM - 1]}},
                        i_Psum[BITS_PSUM*k +: BITS_PSUM]};
      end
   end

   // Control qualifiers. A start is honoured everywhere except DRAIN, and it
   // swallows any done pulse arriving in the same cycle.
   always_comb begin
      start_acc   = i_Start && (state_q != S_DRAIN);
      done_acc    = i_Done && !i_Start && (state_q == S_ACCUM);
      cnt_inc     = cnt_q + 8'd1;
      last_tile   = done_acc && (cnt_inc == num_q);
      hs          = (state_q == S_DRAIN) && i_Out_Ready;
      hs_last     = hs && (idx_q == LAST_IDX);
      idx_nxt     = idx_q + 1'b1;
      overrun_set = i_Done && !start_acc && (state_q != S_ACCUM);
   end

   // FSM: state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (i_Start) begin
               state_d = S_ACCUM;
            end else if (last_tile) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (hs_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs (word data and index come straight from registers)
   always_comb begin
      o_Out_Valid = (state_q == S_DRAIN);
      o_Busy      = (state_q != S_IDLE);
      o_Last      = (state_q == S_DRAIN) && (idx_q == LAST_IDX);
      o_Out_Data  = data_q;
      o_Out_Idx   = idx_q;
      o_Overrun   = overrun_q;
   end

   // Datapath next-state
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      shift_d   = shift_q;
      relu_d    = relu_q;
      idx_d     = idx_q;
      data_d    = data_q;
      overrun_d = overrun_q;

      if (start_acc) begin
         for (int k = 0; k < PE_ARRAY; k++) begin
            acc_d[k] = '0;
         end
         cnt_d     = '0;
         num_d     = (i_Num_Tiles == 8'd0) ? 8'd1 : i_Num_Tiles;
         shift_d   = i_Shift;
         relu_d    = i_Relu;
         overrun_d = 1'b0;
      end else if (done_acc) begin
         for (int k = 0; k < PE_ARRAY; k++) begin
            acc_d[k] = acc_q[k] + psum_ext[k];
         end
         cnt_d = last_tile ? 8'd0 : cnt_inc;
      end

      if (overrun_set) begin
         overrun_d = 1'b1;
      end

      // Lane 0 is requantized from the freshly summed value so its word is
      // ready on the first DRAIN cycle; later lanes are prepared on each
      // handshake from the settled accumulators.
      if (last_tile) begin
         idx_d  = '0;
         data_d = requant(acc_d[0], shift_q, relu_q);
      end else if (hs_last) begin
         idx_d  = '0;
         data_d = '0;
      end else if (hs) begin
         idx_d  = idx_nxt;
         data_d = requant(acc_q[idx_nxt], shift_q, relu_q);
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < PE_ARRAY; k++) begin
            acc_q[k] <= '0;
         end
         cnt_q     <= '0;
         num_q     <= 8'd1;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         for (int k = 0; k < PE_ARRAY; k++) begin
            acc_q[k] <= acc_d[k];
         end
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         shift_q   <= shift_d;
         relu_q    <= relu_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: doc/bb_psum_accum.md
Name: bb_psum_accum

Overview:
Sits directly downstream of the BitBlade core. It captures the core's PE_ARRAY partial sums on each done pulse and accumulates them across a programmed number of tiles. It then requantizes each sum (rounding shift, optional ReLU, saturation) and streams the results one per cycle over a valid/ready handshake toward the output buffer.

Parameters:
PE_ARRAY, 16, number of partial-sum lanes delivered per done pulse
BITS_PSUM, 20, width of each signed partial sum from the core
BITS_OUT, 8, width of each signed requantized output
ACC_EXT, 8, guard bits; accumulator width ACC_W = BITS_PSUM+ACC_EXT

Ports:
CLK  input  1  clock
RST  input  1  asynchronous active-low reset
i_Start  input  1  one-cycle pulse; latches config, clears accumulators, enters ACCUM
i_Num_Tiles  input  8  done pulses to accumulate per output set (0 treated as 1)
i_Shift  input  5  arithmetic right-shift amount for requantization
i_Relu  input  1  1 = clamp negatives to 0 before saturation
i_Done  input  1  core done pulse; i_Psum valid in the same cycle
i_Psum  input  BITS_PSUM*PE_ARRAY  packed signed partial sums; lane k at [BITS_PSUM*k +: BITS_PSUM]
o_Out_Valid  output  1  output word valid
i_Out_Ready  input  1  downstream accepts word
o_Out_Data  output  BITS_OUT  requantized signed value of lane o_Out_Idx
o_Out_Idx  output  4  lane index of current word
o_Last  output  1  high with the word of lane PE_ARRAY-1
o_Busy  output  1  high in ACCUM or DRAIN
o_Overrun  output  1  sticky; set when i_Done arrives outside ACCUM

Behaviour:
- Reset (RST=0, asynchronous):
  - all accumulators 0; tile counter 0; lane index 0; state IDLE.
  - o_Out_Valid=0, o_Out_Data=0, o_Out_Idx=0, o_Last=0, o_Busy=0, o_Overrun=0.
  - Reset mid-operation aborts immediately; no partial outputs are emitted.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - i_Start -> ACCUM; latch i_Num_Tiles (0->1), i_Shift and i_Relu; clear accumulators and tile counter.
  - i_Done in IDLE is ignored and sets o_Overrun.
- ACCUM:
  - On each i_Done, acc[k] <= acc[k] + sign-extended psum[k] for all lanes; tile counter increments.
  - When the counter reaches N, move to DRAIN on that same edge.
  - i_Start in ACCUM restarts: config relatched, accumulators cleared, and any coincident i_Done is discarded.
- DRAIN:
  - o_Out_Valid=1 from the first cycle after the edge that captured the final i_Done.
  - o_Out_Data and o_Out_Idx are registered and hold stable while Valid=1 and Ready=0.
  - Each Valid&&Ready handshake advances the lane index 0..PE_ARRAY-1, one word per cycle when Ready is held high.
  - The handshake on lane PE_ARRAY-1, which has o_Last=1, returns to IDLE with Valid=0 the next cycle.
  - i_Done in DRAIN is dropped and sets o_Overrun.
  - i_Start in DRAIN is ignored.
  - o_Overrun clears only on reset or an accepted i_Start.
- Requantization of lane k:
  - If s>0: r = (acc + (1<<(s-1))) >>> s, arithmetic shift with round-half-up. If s=0: r = acc.
  - If relu=1 and r<0, then r=0.
  - Saturate to [-2^(BITS_OUT-1), 2^(BITS_OUT-1)-1].
  - Shifts of s >= ACC_W yield 0 for non-negative accumulators and -1 for negative ones (pre-ReLU).
- Accumulator wrap: ACC_W is sized for up to 2^ACC_EXT tiles of full-scale psums. There is no internal overflow detection; 256 tiles of full-scale input is the guaranteed bound.
- Throughput: with Ready held high, PE_ARRAY output cycles plus 1 idle cycle separate the final i_Done from acceptance of the next i_Start.

Test Plan:
- Reset mid-DRAIN at lane 5 -> all outputs 0, state IDLE. The next i_Start/i_Done with N=1 streams lanes 0..15 starting at index 0.
- N=1, s=0, relu=0, psum[k]=k-8, Ready=1 -> 16 consecutive words -8..7, Idx 0..15, o_Last only on Idx 15, Valid asserted 1 cycle after i_Done.
- N=3, s=2, psum all lanes=+5 each tile -> acc=15, (15+2)>>>2=4 on every lane. With psum=-5: (-15+2)>>>2=-4, and relu=1 gives 0.
- Saturation: N=1, s=0, psum=+300 / -300 -> outputs +127 / -128.
- Backpressure: Ready toggling 1,0,0,1,... -> Data/Idx held constant while Ready=0, no lane skipped or duplicated, 16 words total.
- Overrun: i_Done during DRAIN and in IDLE -> o_Overrun=1, DRAIN output values unchanged. The next i_Start clears o_Overrun to 0.
